// File: rtl/norm_calc.sv
// Row-wise Euclidean norm of a 4x4 fixed-point matrix: one shared squarer
// followed by a restoring bit-serial integer square root per row.
module norm_calc #(
    parameter int DW        = 26,
    parameter int FRAC_BITS = 20
) (
    input  logic             clk_ncalc,
    input  logic             rstn_ncalc,
    input  logic             en_ncalc,
    input  logic [16*DW-1:0] w_in,
    output logic [DW-1:0]    norm_r1,
    output logic [DW-1:0]    norm_r2,
    output logic [DW-1:0]    norm_r3,
    output logic [DW-1:0]    norm_r4,
    output logic [3:0]       zero_row,
    output logic [3:0]       sat_row,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DW + 1);
    localparam int AW = 2 * DW + 2;
    localparam int RW = DW + 4;
    // Q(2F) radicand yields a Q(F) root directly; kept explicit for other formats
    localparam int ROOT_SHIFT = (2 * FRAC_BITS) / 2 - FRAC_BITS;
    localparam logic [CW-1:0] SQ_LAST   = CW'(3);
    localparam logic [CW-1:0] SQRT_LAST = CW'(DW);
    localparam logic [DW-1:0] SAT_VAL   = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQ,
        S_SQRT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [DW-1:0]  r_w [16];
    logic [1:0]            r_row;
    logic [CW-1:0]         r_cnt;
    logic [AW-1:0]         r_acc;
    logic [AW-1:0]         r_rad;
    logic [RW-1:0]         r_rem;
    logic [DW:0]           r_root;
    logic [DW-1:0]         r_norm [4];
    logic [3:0]            r_zero;
    logic [3:0]            r_sat;

    logic signed [DW-1:0]   w_elem;
    logic signed [2*DW-1:0] w_sq;
    logic [AW-1:0]          w_acc_sum;
    logic [RW-1:0]          w_rem_sh;
    logic [RW-1:0]          w_trial;
    logic [RW-1:0]          w_rem_nxt;
    logic                   w_ge;
    logic [DW:0]            w_root_nxt;
    logic [DW:0]            w_root_q;
    logic                   w_sat;
    logic                   w_sq_last;
    logic                   w_sqrt_last;

    assign w_elem    = r_w[{r_row, r_cnt[1:0]}];
    assign w_sq      = w_elem * w_elem;
    assign w_acc_sum = r_acc + AW'($unsigned(w_sq));

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1
    assign w_rem_sh   = (r_rem << 2) | RW'(r_rad[AW-1 -: 2]);
    assign w_trial    = {1'b0, r_root, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = (r_root << 1) | (DW+1)'(w_ge);
    assign w_root_q   = w_root_nxt >> ROOT_SHIFT;
    assign w_sat      = |w_root_q[DW:DW-1];

    assign w_sq_last   = (r_cnt == SQ_LAST);
    assign w_sqrt_last = (r_cnt == SQRT_LAST);

    always_ff @(posedge clk_ncalc or negedge rstn_ncalc) begin
        if (!rstn_ncalc) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (en_ncalc) w_state_nxt = S_SQ;
            S_SQ:   if (w_sq_last) w_state_nxt = S_SQRT;
            S_SQRT: if (w_sqrt_last) w_state_nxt = (r_row == 2'd3) ? S_DONE : S_SQ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ncalc or negedge rstn_ncalc) begin
        if (!rstn_ncalc) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                r_norm[i] <= '0;
            end
            r_row  <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_zero <= '0;
            r_sat  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (en_ncalc) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            r_w[i] <= w_in[i*DW +: DW];
                        end
                        r_row  <= '0;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_zero <= '0;
                        r_sat  <= '0;
                    end
                end
                S_SQ: begin
                    r_acc <= w_acc_sum;
                    if (w_sq_last) begin
                        r_rad  <= w_acc_sum;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SQRT: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    if (w_sqrt_last) begin
                        r_norm[r_row] <= w_sat ? SAT_VAL : w_root_q[DW-1:0];
                        r_sat[r_row]  <= w_sat;
                        r_zero[r_row] <= (r_acc == '0);
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        r_row         <= r_row + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign norm_r1  = r_norm[0];
    assign norm_r2  = r_norm[1];
    assign norm_r3  = r_norm[2];
    assign norm_r4  = r_norm[3];
    assign zero_row = r_zero;
    assign sat_row  = r_sat;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_norm_calc.sv
// Bench for norm_calc: fixed vector table, random rows against an arithmetic
// reference model, and sequences for reset abort, ignored starts and back-to-back runs.
module tb_norm_calc;

    localparam int DW = 26;
    localparam int WB = 16 * DW;
    localparam longint SATV = (longint'(1) << (DW - 1)) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [WB-1:0] w_in;
    logic [DW-1:0] norm_r1, norm_r2, norm_r3, norm_r4;
    logic [3:0]    zero_row, sat_row;
    logic          busy, done;

    always #5 clk = ~clk;

    norm_calc #(.DW(DW), .FRAC_BITS(20)) dut (
        .clk_ncalc  (clk),
        .rstn_ncalc (rstn),
        .en_ncalc   (en),
        .w_in       (w_in),
        .norm_r1    (norm_r1),
        .norm_r2    (norm_r2),
        .norm_r3    (norm_r3),
        .norm_r4    (norm_r4),
        .zero_row   (zero_row),
        .sat_row    (sat_row),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [WB-1:0] w;
        longint        n1, n2, n3, n4;
        logic [3:0]    z;
        logic [3:0]    s;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    longint     exp_n [4];
    logic [3:0] exp_z;
    logic [3:0] exp_s;

    function automatic void chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    function automatic logic [WB-1:0] put(logic [WB-1:0] w, int r, int c, int v);
        logic [31:0] vv;
        vv = v;
        w[((r-1)*4 + (c-1))*DW +: DW] = vv[DW-1:0];
        return w;
    endfunction

    function automatic longint isqrt(longint s);
        longint r;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Reference: plain sum of squares, floor square root, clamp to DW-1 bits
    function automatic void model(logic [WB-1:0] w);
        for (int r = 0; r < 4; r++) begin
            longint s;
            longint q;
            s = 0;
            for (int c = 0; c < 4; c++) begin
                logic [DW-1:0] e;
                longint v;
                e = w[(r*4 + c)*DW +: DW];
                v = longint'($signed(e));
                s += v * v;
            end
            q = isqrt(s);
            exp_z[r] = (s == 0);
            exp_s[r] = (q > SATV);
            exp_n[r] = (q > SATV) ? SATV : q;
        end
    endfunction

    function automatic logic [WB-1:0] rand_w();
        logic [WB-1:0] w;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            int unsigned mode;
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 4; c++) begin
                logic [DW-1:0] e;
                logic [31:0]   u;
                u = $urandom;
                case (mode)
                    0: e = u[DW-1:0];
                    1: begin
                        u = $urandom_range(0, 4194303) - 2097152;
                        e = u[DW-1:0];
                    end
                    2: e = '0;
                    default: e = {1'b1, {(DW-1){1'b0}}};
                endcase
                w[(r*4 + c)*DW +: DW] = e;
            end
        end
        return w;
    endfunction

    task automatic check_outputs(string tag);
        chk({tag, " norm_r1"}, longint'(norm_r1), exp_n[0]);
        chk({tag, " norm_r2"}, longint'(norm_r2), exp_n[1]);
        chk({tag, " norm_r3"}, longint'(norm_r3), exp_n[2]);
        chk({tag, " norm_r4"}, longint'(norm_r4), exp_n[3]);
        chk({tag, " zero_row"}, longint'(zero_row), longint'(exp_z));
        chk({tag, " sat_row"}, longint'(sat_row), longint'(exp_s));
    endtask

    task automatic run(logic [WB-1:0] w, string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        w_in = w;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        chk({tag, " busy after capture"}, longint'(busy), 1);
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        chk({tag, " done latency"}, lat, 124);
        chk({tag, " busy with done"}, longint'(busy), 1);
        check_outputs(tag);
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, longint'(done), 0);
        chk({tag, " busy released"}, longint'(busy), 0);
    endtask

    vec_t          tbl [4];
    logic [WB-1:0] w_id;
    logic [WB-1:0] w_a;
    logic [WB-1:0] w_b;
    int            nd;
    int            t_first;
    int            t_second;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        w_in = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_n = '{0, 0, 0, 0};
        exp_z = 4'b0000;
        exp_s = 4'b0000;
        check_outputs("reset");
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        @(negedge clk);
        rstn = 1'b1;

        w_id = '0;
        for (int r = 1; r <= 4; r++) w_id = put(w_id, r, r, 1048576);

        tbl[0].w = w_id;
        tbl[0].n1 = 1048576; tbl[0].n2 = 1048576; tbl[0].n3 = 1048576; tbl[0].n4 = 1048576;
        tbl[0].z = 4'b0000; tbl[0].s = 4'b0000;

        tbl[1].w = put(put('0, 1, 1, 3145728), 1, 2, -4194304);
        tbl[1].n1 = 5242880; tbl[1].n2 = 0; tbl[1].n3 = 0; tbl[1].n4 = 0;
        tbl[1].z = 4'b1110; tbl[1].s = 4'b0000;

        tbl[2].w = '0;
        for (int c = 1; c <= 4; c++) tbl[2].w = put(tbl[2].w, 2, c, -1048576);
        tbl[2].n1 = 0; tbl[2].n2 = 2097152; tbl[2].n3 = 0; tbl[2].n4 = 0;
        tbl[2].z = 4'b1101; tbl[2].s = 4'b0000;

        tbl[3].w = put(put(put('0, 1, 1, 1048576), 2, 2, 1048576), 4, 4, 1048576);
        for (int c = 1; c <= 4; c++) tbl[3].w = put(tbl[3].w, 3, c, -33554432);
        tbl[3].n1 = 1048576; tbl[3].n2 = 1048576; tbl[3].n3 = 33554431; tbl[3].n4 = 1048576;
        tbl[3].z = 4'b0000; tbl[3].s = 4'b0100;

        for (int i = 0; i < 4; i++) begin
            exp_n = '{tbl[i].n1, tbl[i].n2, tbl[i].n3, tbl[i].n4};
            exp_z = tbl[i].z;
            exp_s = tbl[i].s;
            run(tbl[i].w, $sformatf("vec%0d", i));
        end

        for (int k = 0; k < 8; k++) begin
            w_a = rand_w();
            model(w_a);
            run(w_a, $sformatf("rand%0d", k));
        end

        // Reset in the middle of a run clears everything immediately
        @(negedge clk);
        w_in = w_id;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_n = '{0, 0, 0, 0};
        exp_z = 4'b0000;
        exp_s = 4'b0000;
        check_outputs("async reset");
        chk("async reset busy", longint'(busy), 0);
        chk("async reset done", longint'(done), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("no done after reset", nd, 0);
        exp_n = '{1048576, 1048576, 1048576, 1048576};
        run(w_id, "post reset");

        // Starts while busy are ignored and later w_in changes do not leak in
        w_a = rand_w();
        w_b = rand_w();
        model(w_a);
        @(negedge clk);
        w_in = w_a;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        nd = 0;
        for (int cyc = 1; cyc <= 260; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (nd == 1) check_outputs("ignored start");
            end
            if (cyc == 9 || cyc == 59) begin
                en   = 1'b1;
                w_in = w_b;
            end else begin
                en = 1'b0;
            end
        end
        chk("ignored start done count", nd, 1);

        // en held high gives back-to-back runs
        w_a = rand_w();
        model(w_a);
        @(negedge clk);
        w_in = w_a;
        en   = 1'b1;
        nd = 0;
        t_first = 0;
        t_second = 0;
        for (int cyc = 1; cyc <= 400 && nd < 2; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (nd == 1) t_first = cyc;
                else begin
                    t_second = cyc;
                    en = 1'b0;
                end
            end
        end
        en = 1'b0;
        chk("held en done count", nd, 2);
        chk("held en spacing", t_second - t_first, 126);
        check_outputs("held en");
        repeat (3) @(posedge clk);
        #1;
        chk("held en idle after", longint'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
